// File: rtl/irq_ctl.sv
// irq_ctl: small CP0-style exception and interrupt controller.
// It sits next to decode. It synchronises the external interrupt lines and
// applies the Status mask and enable. On entry it captures EPC and the Cause
// code. It drives a PC-select override toward the handler vector and, on
// eret, back to EPC.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  USER    | normal execution; exceptions and enabled interrupts are taken
//  ENTER   | one-cycle entry: irq pulse to decode, fetch redirected to VECTOR
//  HANDLER | supervisor mode; interrupts ignored, CP0 writable, eret returns
//  HALT    | double fault; sticky until reset, no redirects
module irq_ctl #(
   parameter int          NUM_IRQ = 4,
   parameter logic [31:0] VECTOR  = 32'h0000_0080
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               exception,
   input  logic               instr_valid,
   input  logic [31:0]        pc,
   input  logic               eret,
   input  logic               cp0_we,
   input  logic [4:0]         cp0_addr,
   input  logic [31:0]        cp0_wdata,
   output logic [31:0]        cp0_rdata,
   output logic               irq,
   output logic               supervisor,
   output logic               redirect,
   output logic [31:0]        redirect_pc,
   output logic               fault
);

   localparam logic [1:0] ST_USER    = 2'd0;
   localparam logic [1:0] ST_ENTER   = 2'd1;
   localparam logic [1:0] ST_HANDLER = 2'd2;
   localparam logic [1:0] ST_HALT    = 2'd3;

   localparam logic [4:0] ADDR_STATUS = 5'd12;
   localparam logic [4:0] ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] ADDR_EPC    = 5'd14;

   localparam logic [4:0] CODE_INT = 5'd0;
   localparam logic [4:0] CODE_RI  = 5'd10;

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [NUM_IRQ-1:0] sync_a;
   logic [NUM_IRQ-1:0] sync_b;
   logic [NUM_IRQ-1:0] pend;
   logic               status_ie;
   logic [NUM_IRQ-1:0] status_mask;
   logic [4:0]         cause_code;
   logic [31:0]        epc;

   logic               take_exc;
   logic               take_int;
   logic               handler_eret;
   logic               cp0_wr_ok;

   // two-flop synchroniser on each asynchronous interrupt line
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= irq_in;
         sync_b <= sync_a;
      end
   end

   assign pend = sync_b & status_mask;

   // An eret seen in USER has no handler to return from, so it is treated
   // like an illegal instruction. A faulting retire always beats an
   // interrupt on the same cycle.
   assign take_exc     = (state == ST_USER) && instr_valid && (exception || eret);
   assign take_int     = (state == ST_USER) && instr_valid && !(exception || eret)
                         && status_ie && (|pend);
   assign handler_eret = (state == ST_HANDLER) && instr_valid && eret;
   assign cp0_wr_ok    = (state == ST_HANDLER) && cp0_we;

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_USER: begin
            if (take_exc || take_int) begin
               state_nxt = ST_ENTER;
            end
         end
         ST_ENTER: begin
            state_nxt = ST_HANDLER;
         end
         ST_HANDLER: begin
            if (handler_eret) begin
               state_nxt = ST_USER;
            end else if (instr_valid && exception) begin
               state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
         default: begin
            state_nxt = ST_USER;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_USER;
      end else begin
         state <= state_nxt;
      end
   end

   // Status register. It is written only from the handler so that user code
   // cannot unmask itself.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         status_ie   <= 1'b0;
         status_mask <= '0;
      end else if (cp0_wr_ok && (cp0_addr == ADDR_STATUS)) begin
         status_ie   <= cp0_wdata[0];
         status_mask <= cp0_wdata[8 +: NUM_IRQ];
      end
   end

   // Capture EPC and the cause code on entry. The handler may rewrite EPC.
   // Capture happens only in USER and writes happen only in HANDLER, so the
   // two never collide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         epc        <= '0;
         cause_code <= '0;
      end else if (take_exc) begin
         epc        <= pc;
         cause_code <= CODE_RI;
      end else if (take_int) begin
         epc        <= pc;
         cause_code <= CODE_INT;
      end else if (cp0_wr_ok && (cp0_addr == ADDR_EPC)) begin
         epc <= cp0_wdata;
      end
   end

   // combinational CP0 read port; unmapped addresses read as zero
   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         ADDR_STATUS: begin
            cp0_rdata[0]             = status_ie;
            cp0_rdata[8 +: NUM_IRQ]  = status_mask;
         end
         ADDR_CAUSE: begin
            cp0_rdata[6:2]           = cause_code;
            cp0_rdata[8 +: NUM_IRQ]  = pend;
         end
         ADDR_EPC: begin
            cp0_rdata = epc;
         end
         default: begin
            cp0_rdata = '0;
         end
      endcase
   end

   // Most outputs are decoded from state alone. The eret redirect is the
   // exception: it is taken on the eret cycle itself, from the EPC value
   // held before any same-cycle write.
   always_comb begin
      irq         = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      supervisor  = 1'b0;
      fault       = 1'b0;
      case (state)
         ST_ENTER: begin
            irq         = 1'b1;
            redirect    = 1'b1;
            redirect_pc = VECTOR;
         end
         ST_HANDLER: begin
            supervisor = 1'b1;
            if (handler_eret) begin
               redirect    = 1'b1;
               redirect_pc = epc;
            end
         end
         ST_HALT: begin
            supervisor = 1'b1;
            fault      = 1'b1;
         end
         default: begin
            irq = 1'b0;
         end
      endcase
   end

endmodule
